// File: rtl/apb_cmd_master_if.sv
// Command/response stream and APB3 bus bundle for apb_cmd_master.
// The master modport is the requester side; the slave modport is the far side.
interface apb_cmd_master_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_wdata;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;
    logic                  rsp_timeout;

    logic                  PSEL;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [ADDR_WIDTH-1:0] PADDR;
    logic [DATA_WIDTH-1:0] PWDATA;
    logic [DATA_WIDTH-1:0] PRDATA;
    logic                  PREADY;
    logic                  PSLVERR;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        input  rsp_ready,
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        output rsp_ready,
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_cmd_master.sv
// APB3 requester: one outstanding command turned into a SETUP/ACCESS transfer,
// with a PREADY wait limit so a hung slave still yields an error response.
module apb_cmd_master #(
    parameter int ADDR_WIDTH     = 10,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int TO_WIDTH       = 8
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    apb_cmd_master_if.master  bus
);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } state_t;

    localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [TO_WIDTH-1:0] TO_LAST =
        TO_WIDTH'(TO_EN ? TIMEOUT_CYCLES - 1 : 0);

    state_t                state_q,       state_d;
    logic                  psel_q,        psel_d;
    logic                  penable_q,     penable_d;
    logic                  pwrite_q,      pwrite_d;
    logic [ADDR_WIDTH-1:0] paddr_q,       paddr_d;
    logic [DATA_WIDTH-1:0] pwdata_q,      pwdata_d;
    logic                  rsp_valid_q,   rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q,   rsp_rdata_d;
    logic                  rsp_err_q,     rsp_err_d;
    logic                  rsp_timeout_q, rsp_timeout_d;
    logic [TO_WIDTH-1:0]   wait_q,        wait_d;

    // State, bus and response registers; reset drops any in-flight transfer.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q       <= IDLE;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            wait_q        <= '0;
        end else begin
            state_q       <= state_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            pwrite_q      <= pwrite_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
            wait_q        <= wait_d;
        end
    end

    // Next-state and next-output logic; everything holds unless a phase moves it.
    always_comb begin
        state_d       = state_q;
        psel_d        = psel_q;
        penable_d     = penable_q;
        pwrite_d      = pwrite_q;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;
        wait_d        = wait_q;

        unique case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    pwrite_d = bus.cmd_write;
                    paddr_d  = bus.cmd_addr;
                    pwdata_d = bus.cmd_wdata;
                    psel_d   = 1'b1;
                    wait_d   = '0;
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                state_d   = ACCESS;
            end
            ACCESS: begin
                if (bus.PREADY) begin
                    rsp_rdata_d   = pwrite_q ? '0 : bus.PRDATA;
                    rsp_err_d     = bus.PSLVERR;
                    rsp_timeout_d = 1'b0;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    state_d       = RESP;
                end else if (TO_EN && (wait_q == TO_LAST)) begin
                    rsp_rdata_d   = '0;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    state_d       = RESP;
                end else if (TO_EN) begin
                    wait_d = wait_q + TO_WIDTH'(1);
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.cmd_ready   = (state_q == IDLE);
    assign bus.PSEL        = psel_q;
    assign bus.PENABLE     = penable_q;
    assign bus.PWRITE      = pwrite_q;
    assign bus.PADDR       = paddr_q;
    assign bus.PWDATA      = pwdata_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rdata   = rsp_rdata_q;
    assign bus.rsp_err     = rsp_err_q;
    assign bus.rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Bench for apb_cmd_master: directed cases plus random transfers against
// a transaction-level expectation of latency, bus phases and response.
module tb_apb_cmd_master;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int T  = 16;

    logic PCLK    = 1'b0;
    logic PRESETn = 1'b1;

    always #5 PCLK = ~PCLK;

    apb_cmd_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bi();
    apb_cmd_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bz();

    apb_cmd_master #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
        .TIMEOUT_CYCLES(T), .TO_WIDTH(8)
    ) dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .bus(bi.master)
    );

    apb_cmd_master #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
        .TIMEOUT_CYCLES(0), .TO_WIDTH(8)
    ) dut_nto (
        .PCLK(PCLK), .PRESETn(PRESETn), .bus(bz.master)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One command through the bus slave; w = PREADY-low ACCESS cycles
    // before PREADY rises (w >= T means the slave never answers in time).
    task automatic xfer(input bit wr, input logic [AW-1:0] a,
                        input logic [DW-1:0] wd, input int w,
                        input logic [DW-1:0] rd, input bit se,
                        input int hold);
        bit eto, ee, done, stable, hst;
        int epen, edges, pc, ec, acc;
        logic [DW-1:0] er;
        logic [DW+1:0] snap;

        eto  = (T != 0) && (w >= T);
        epen = eto ? T : w + 1;
        ee   = eto ? 1'b1 : se;
        er   = (eto || wr) ? '0 : rd;

        @(negedge PCLK);
        chk("idle_ready", 64'(bi.cmd_ready), 64'(1));
        bi.cmd_valid = 1'b1;
        bi.cmd_write = wr;
        bi.cmd_addr  = a;
        bi.cmd_wdata = wd;
        bi.rsp_ready = 1'b0;
        @(posedge PCLK);
        edges = 0; pc = 0; ec = 0; acc = 0;
        stable = 1'b1; done = 1'b0;
        while (!done && edges < 200) begin
            @(negedge PCLK);
            bi.cmd_valid = 1'b0;
            if (bi.rsp_valid) begin
                done = 1'b1;
            end else begin
                if (bi.PSEL) pc++;
                if (bi.PENABLE) ec++;
                if (bi.PADDR !== a || bi.PWDATA !== wd || bi.PWRITE !== wr)
                    stable = 1'b0;
                if (bi.PSEL && bi.PENABLE) begin
                    bi.PREADY  = (acc == w);
                    bi.PRDATA  = (acc == w) ? rd : DW'($urandom);
                    bi.PSLVERR = (acc == w) ? se : 1'($urandom_range(0, 1));
                    acc++;
                end else begin
                    bi.PREADY  = 1'b0;
                    bi.PSLVERR = 1'($urandom_range(0, 1));
                end
                @(posedge PCLK);
                edges++;
            end
        end
        bi.PREADY  = 1'b0;
        bi.PSLVERR = 1'b0;

        chk("rsp_seen", 64'(done), 64'(1));
        chk("latency", 64'(edges), 64'(epen + 1));
        chk("psel_cyc", 64'(pc), 64'(epen + 1));
        chk("pen_cyc", 64'(ec), 64'(epen));
        chk("addr_stable", 64'(stable), 64'(1));
        chk("bus_idle", 64'({bi.PSEL, bi.PENABLE}), 64'(0));
        chk("rdata", 64'(bi.rsp_rdata), 64'(er));
        chk("err_to", 64'({bi.rsp_err, bi.rsp_timeout}), 64'({ee, eto}));

        snap = {bi.rsp_rdata, bi.rsp_err, bi.rsp_timeout};
        hst  = 1'b1;
        repeat (hold) begin
            @(negedge PCLK);
            if (!bi.rsp_valid || bi.cmd_ready ||
                {bi.rsp_rdata, bi.rsp_err, bi.rsp_timeout} !== snap)
                hst = 1'b0;
        end
        chk("rsp_hold", 64'(hst), 64'(1));
        bi.rsp_ready = 1'b1;
        @(posedge PCLK);
        @(negedge PCLK);
        bi.rsp_ready = 1'b0;
        chk("rsp_done", 64'({bi.rsp_valid, bi.cmd_ready}), 64'(2'b01));
        chk("addr_kept", 64'(bi.PADDR), 64'(a));
    endtask

    initial begin
        int acc_t[$];
        logic [DW-1:0] b2b_rd;
        bit ok;

        bi.cmd_valid = 0; bi.cmd_write = 0; bi.cmd_addr = '0;
        bi.cmd_wdata = '0; bi.rsp_ready = 0; bi.PRDATA = '0;
        bi.PREADY = 0; bi.PSLVERR = 0;
        bz.cmd_valid = 0; bz.cmd_write = 0; bz.cmd_addr = '0;
        bz.cmd_wdata = '0; bz.rsp_ready = 0; bz.PRDATA = '0;
        bz.PREADY = 0; bz.PSLVERR = 0;

        #1 PRESETn = 1'b0;
        #3;
        chk("rst_ctl", 64'({bi.cmd_ready, bi.PSEL, bi.PENABLE, bi.PWRITE,
                            bi.rsp_valid, bi.rsp_err, bi.rsp_timeout}),
            64'(7'b1000000));
        chk("rst_addr", 64'(bi.PADDR), 64'(0));
        chk("rst_wdata", 64'(bi.PWDATA), 64'(0));
        chk("rst_rdata", 64'(bi.rsp_rdata), 64'(0));
        repeat (2) @(negedge PCLK);
        PRESETn = 1'b1;

        xfer(1'b1, 10'h008, 32'h5, 0, 32'h0, 1'b0, 0);
        xfer(1'b0, 10'h004, 32'h0, 0, 32'hA, 1'b0, 0);
        xfer(1'b0, 10'h00C, 32'h0, 0, 32'h1234_5678, 1'b1, 1);
        xfer(1'b1, 10'h000, 32'hDEAD_BEEF, 3, 32'h0, 1'b0, 2);
        xfer(1'b0, 10'h004, 32'h0, 100, 32'h77, 1'b0, 0);
        xfer(1'b0, 10'h004, 32'h0, T - 1, 32'h55, 1'b0, 0);
        xfer(1'b0, 10'h008, 32'h0, T, 32'h66, 1'b0, 5);

        // Back-to-back reads with rsp_ready and PREADY held high.
        @(negedge PCLK);
        bi.cmd_valid = 1'b1; bi.cmd_write = 1'b0; bi.cmd_addr = 10'h004;
        bi.PREADY = 1'b1; bi.PRDATA = 32'hA; bi.rsp_ready = 1'b1;
        b2b_rd = '0;
        for (int c = 0; c < 10; c++) begin
            if (bi.cmd_ready) acc_t.push_back(c);
            if (bi.rsp_valid) b2b_rd = bi.rsp_rdata;
            @(negedge PCLK);
        end
        bi.cmd_valid = 1'b0;
        chk("b2b_cnt", 64'(acc_t.size()), 64'(3));
        if (acc_t.size() >= 2)
            chk("b2b_gap", 64'(acc_t[1] - acc_t[0]), 64'(4));
        chk("b2b_rdata", 64'(b2b_rd), 64'(32'hA));
        repeat (6) @(negedge PCLK);
        bi.PREADY = 1'b0; bi.rsp_ready = 1'b0;
        chk("b2b_drain", 64'({bi.cmd_ready, bi.rsp_valid}), 64'(2'b10));

        // Reset in the middle of an ACCESS wait.
        bi.cmd_valid = 1'b1; bi.cmd_write = 1'b1;
        bi.cmd_addr = 10'h008; bi.cmd_wdata = 32'h3;
        @(posedge PCLK);
        @(negedge PCLK);
        bi.cmd_valid = 1'b0;
        repeat (3) @(negedge PCLK);
        chk("pre_rst_acc", 64'({bi.PSEL, bi.PENABLE}), 64'(2'b11));
        #2 PRESETn = 1'b0;
        #1;
        chk("async_rst", 64'({bi.PSEL, bi.PENABLE, bi.rsp_valid,
                              bi.cmd_ready}), 64'(4'b0001));
        @(negedge PCLK);
        PRESETn = 1'b1;
        ok = 1'b1;
        repeat (4) begin
            @(negedge PCLK);
            if (bi.rsp_valid || !bi.cmd_ready || bi.PSEL) ok = 1'b0;
        end
        chk("post_rst", 64'(ok), 64'(1));

        for (int i = 0; i < 25; i++) begin
            xfer(1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom),
                 ($urandom_range(0, 7) == 0) ? int'($urandom_range(13, 20))
                                              : int'($urandom_range(0, 4)),
                 DW'($urandom), ($urandom_range(0, 3) == 0),
                 int'($urandom_range(0, 5)));
        end

        // Instance with the timeout disabled waits as long as PREADY is low.
        @(negedge PCLK);
        bz.cmd_valid = 1'b1; bz.cmd_write = 1'b1;
        bz.cmd_addr = 10'h008; bz.cmd_wdata = 32'h9;
        @(posedge PCLK);
        @(negedge PCLK);
        bz.cmd_valid = 1'b0;
        repeat (40) @(negedge PCLK);
        chk("nto_wait", 64'({bz.PSEL, bz.PENABLE, bz.rsp_valid}),
            64'(3'b110));
        bz.PREADY = 1'b1;
        @(negedge PCLK);
        bz.PREADY = 1'b0;
        chk("nto_done", 64'({bz.rsp_valid, bz.rsp_err, bz.rsp_timeout}),
            64'(3'b100));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
